// File: rtl/lane_event_fifo.sv
// Lane key event capture: turns keyboard level changes into timestamped press/release
// events, buffers them in a first-word-fall-through queue, and tracks held lanes.
module lane_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16
) (
  input  logic                      clk_in,
  input  logic                      key_reset,
  input  logic                      key_state,
  input  logic [3:0]                key_ascii,
  input  logic [TS_W-1:0]           game_time,
  input  logic                      clear,
  input  logic                      evt_pop,
  output logic                      evt_valid,
  output logic [2:0]                evt_lane,
  output logic                      evt_press,
  output logic [TS_W-1:0]           evt_time,
  output logic [$clog2(DEPTH):0]    evt_count,
  output logic [5:0]                lane_held,
  output logic                      overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = TS_W + 4;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_n, wr_n;
  logic             prev_state, armed;
  logic [2:0]       prev_lane, cur_lane;

  logic             rel, prs, pop, drop;
  logic [1:0]       n_req, n_push;
  logic [CNT_W-1:0] free, remain, count_n;
  logic [ENT_W-1:0] ent0, ent1, head_n;
  logic [5:0]       held_n;

  // Event detection, queue space arbitration (release wins a single free slot) and next head.
  always_comb begin
    cur_lane = 3'd0;
    if (key_ascii >= 4'd1 && key_ascii <= 4'd6) cur_lane = key_ascii[2:0];

    // armed is low for the first cycle after reset so keys held across reset stay silent
    rel = armed & prev_state & (prev_lane != 3'd0) & (~key_state | (cur_lane != prev_lane));
    prs = armed & key_state & (cur_lane != 3'd0) & (~prev_state | (cur_lane != prev_lane));

    ent0 = rel ? {prev_lane, 1'b0, game_time} : {cur_lane, 1'b1, game_time};
    ent1 = {cur_lane, 1'b1, game_time};

    pop    = evt_pop & evt_valid;
    free   = CNT_W'(DEPTH) - evt_count + CNT_W'(pop);
    n_req  = 2'(rel) + 2'(prs);
    drop   = CNT_W'(n_req) > free;
    n_push = drop ? free[1:0] : n_req;

    remain  = evt_count - CNT_W'(pop);
    count_n = remain + CNT_W'(n_push);
    rd_n    = rd_ptr + PTR_W'(pop);
    wr_n    = wr_ptr + PTR_W'(n_push);

    head_n = '0;
    if (remain == '0) begin
      if (n_push != 2'd0) head_n = ent0;
    end else begin
      head_n = mem[rd_n];
    end

    held_n = lane_held;
    for (int i = 0; i < 6; i++) begin
      if (rel && prev_lane == 3'(i + 1)) held_n[i] = 1'b0;
      if (prs && cur_lane == 3'(i + 1))  held_n[i] = 1'b1;
    end
  end

  // Control state and registered head outputs.
  always_ff @(posedge clk_in or negedge key_reset) begin
    if (!key_reset) begin
      prev_state <= 1'b0;
      prev_lane  <= 3'd0;
      armed      <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      evt_count  <= '0;
      evt_valid  <= 1'b0;
      evt_lane   <= 3'd0;
      evt_press  <= 1'b0;
      evt_time   <= '0;
      lane_held  <= 6'd0;
      overflow   <= 1'b0;
    end else begin
      prev_state <= key_state;
      prev_lane  <= cur_lane;
      armed      <= 1'b1;
      if (clear) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        evt_count <= '0;
        evt_valid <= 1'b0;
        evt_lane  <= 3'd0;
        evt_press <= 1'b0;
        evt_time  <= '0;
        lane_held <= 6'd0;
        overflow  <= 1'b0;
      end else begin
        rd_ptr    <= rd_n;
        wr_ptr    <= wr_n;
        evt_count <= count_n;
        evt_valid <= count_n != '0;
        {evt_lane, evt_press, evt_time} <= head_n;
        lane_held <= held_n;
        overflow  <= overflow | drop;
      end
    end
  end

  // Entry storage; needs no reset since pointers and count define validity.
  always_ff @(posedge clk_in) begin
    if (!clear) begin
      if (n_push != 2'd0) mem[wr_ptr] <= ent0;
      if (n_push == 2'd2) mem[wr_ptr + PTR_W'(1)] <= ent1;
    end
  end

endmodule

// File: tb/tb_lane_event_fifo.sv
// Directed bench for lane_event_fifo with a queue-based reference model checked every cycle.
module tb_lane_event_fifo;

  localparam int DEPTH = 8;
  localparam int TS_W  = 16;

  logic            clk_in, key_reset, key_state, clear, evt_pop;
  logic [3:0]      key_ascii;
  logic [TS_W-1:0] game_time;
  logic            evt_valid, evt_press, overflow;
  logic [2:0]      evt_lane;
  logic [TS_W-1:0] evt_time;
  logic [3:0]      evt_count;
  logic [5:0]      lane_held;

  lane_event_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk_in(clk_in), .key_reset(key_reset), .key_state(key_state), .key_ascii(key_ascii),
    .game_time(game_time), .clear(clear), .evt_pop(evt_pop), .evt_valid(evt_valid),
    .evt_lane(evt_lane), .evt_press(evt_press), .evt_time(evt_time), .evt_count(evt_count),
    .lane_held(lane_held), .overflow(overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask

  // Reference model: event list, held lanes and sticky drop flag.
  typedef struct { int lane; bit press; int t; } ev_t;
  ev_t     mq[$];
  bit [5:0] m_held;
  bit      m_ovf, m_prev_st, m_fresh;
  int      m_prev_ln;

  always begin
    @(posedge clk_in or negedge key_reset);
    if (!key_reset) begin
      mq.delete();
      m_held = '0; m_ovf = 0; m_prev_st = 0; m_prev_ln = 0; m_fresh = 1;
    end else begin
      int cur;
      bit rel, prs;
      ev_t e;
      cur = (key_ascii >= 1 && key_ascii <= 6) ? int'(key_ascii) : 0;
      rel = !m_fresh && m_prev_st && m_prev_ln != 0 && (!key_state || cur != m_prev_ln);
      prs = !m_fresh && key_state && cur != 0 && (!m_prev_st || cur != m_prev_ln);
      if (clear) begin
        mq.delete();
        m_held = '0; m_ovf = 0;
      end else begin
        if (evt_pop && mq.size() > 0) void'(mq.pop_front());
        if (rel) begin
          e.lane = m_prev_ln; e.press = 0; e.t = int'(game_time);
          if (mq.size() < DEPTH) mq.push_back(e); else m_ovf = 1;
          m_held[m_prev_ln-1] = 1'b0;
        end
        if (prs) begin
          e.lane = cur; e.press = 1; e.t = int'(game_time);
          if (mq.size() < DEPTH) mq.push_back(e); else m_ovf = 1;
          m_held[cur-1] = 1'b1;
        end
      end
      m_prev_st = key_state; m_prev_ln = cur; m_fresh = 0;
    end
  end

  always begin
    @(negedge clk_in);
    if (key_reset) begin
      chk("m_valid", 32'(evt_valid), 32'(mq.size() != 0));
      chk("m_count", 32'(evt_count), 32'(mq.size()));
      chk("m_held", 32'(lane_held), 32'(m_held));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
      chk("m_lane", 32'(evt_lane), mq.size() != 0 ? 32'(mq[0].lane) : 32'd0);
      chk("m_press", 32'(evt_press), mq.size() != 0 ? 32'(mq[0].press) : 32'd0);
      chk("m_time", 32'(evt_time), mq.size() != 0 ? 32'(mq[0].t) : 32'd0);
    end
  end

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic head(input string nm, input int ln, input int pr, input int t);
    chk({nm, "_lane"}, 32'(evt_lane), 32'(ln));
    chk({nm, "_press"}, 32'(evt_press), 32'(pr));
    chk({nm, "_time"}, 32'(evt_time), 32'(t));
  endtask

  initial begin
    key_reset = 0; key_state = 0; key_ascii = 0; game_time = 0; clear = 0; evt_pop = 0;
    #3;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_count", 32'(evt_count), 0);
    chk("rst_held", 32'(lane_held), 0);
    chk("rst_ovf", 32'(overflow), 0);
    #9 key_reset = 1;
    step(); step();

    // single press then release
    key_state = 1; key_ascii = 3; game_time = 100; step();
    chk("t1_valid", 32'(evt_valid), 1);
    head("t1", 3, 1, 100);
    chk("t1_held", 32'(lane_held), 32'h04);
    chk("t1_count", 32'(evt_count), 1);
    key_state = 0; key_ascii = 0; game_time = 140; step();
    chk("t2_count", 32'(evt_count), 2);
    chk("t2_held", 32'(lane_held), 0);
    evt_pop = 1; step();
    head("t2", 3, 0, 140);
    step(); evt_pop = 0;
    chk("t2_empty", 32'(evt_valid), 0);
    head("t2e", 0, 0, 0);

    // direct lane switch 1 -> 4
    key_state = 1; key_ascii = 1; game_time = 180; step();
    evt_pop = 1; step(); evt_pop = 0;
    key_ascii = 4; game_time = 200; step();
    chk("t3_count", 32'(evt_count), 2);
    head("t3a", 1, 0, 200);
    chk("t3_held", 32'(lane_held), 32'h08);
    evt_pop = 1; step();
    head("t3b", 4, 1, 200);
    step(); evt_pop = 0;
    key_state = 0; key_ascii = 0; game_time = 220; step();
    evt_pop = 1; step(); evt_pop = 0;

    // nine events into an 8-deep queue
    for (int i = 0; i < 9; i++) begin
      key_state = (i % 2 == 0); key_ascii = key_state ? 4'd2 : 4'd0;
      game_time = 16'(300 + i); step();
    end
    chk("t4_count", 32'(evt_count), 8);
    chk("t4_ovf", 32'(overflow), 1);
    head("t4", 2, 1, 300);
    key_state = 0; key_ascii = 0; game_time = 320; evt_pop = 1; step(); evt_pop = 0;
    chk("t4_full_pp", 32'(evt_count), 8);
    head("t4pp", 2, 0, 301);
    clear = 1; step(); clear = 0;
    chk("clr_count", 32'(evt_count), 0);
    chk("clr_ovf", 32'(overflow), 0);

    // unmapped keys
    key_state = 1; key_ascii = 0; game_time = 400; step();
    chk("t5_nomap0", 32'(evt_count), 0);
    key_ascii = 9; step();
    chk("t5_nomap9", 32'(evt_count), 0);
    chk("t5_held", 32'(lane_held), 0);
    key_state = 0; key_ascii = 0; step();

    // lane switch with one free slot
    for (int i = 0; i < 7; i++) begin
      key_state = (i % 2 == 0); key_ascii = key_state ? 4'd1 : 4'd0;
      game_time = 16'(500 + i); step();
    end
    chk("t5_fill", 32'(evt_count), 7);
    key_ascii = 5; game_time = 520; step();
    chk("t5_sw_count", 32'(evt_count), 8);
    chk("t5_sw_ovf", 32'(overflow), 1);
    chk("t5_sw_held", 32'(lane_held), 32'h10);

    // key held through clear
    clear = 1; step(); clear = 0;
    chk("hc_held", 32'(lane_held), 0);
    step();
    chk("hc_noprs", 32'(evt_count), 0);
    key_state = 0; key_ascii = 0; game_time = 540; step();
    chk("hc_rel_count", 32'(evt_count), 1);
    head("hc", 5, 0, 540);

    // reset mid-operation with lane 2 held
    evt_pop = 1; step(); evt_pop = 0;
    key_state = 1; key_ascii = 6; game_time = 600; step();
    key_state = 0; key_ascii = 0; game_time = 601; step();
    key_state = 1; key_ascii = 2; game_time = 602; step();
    chk("t6_count", 32'(evt_count), 3);
    chk("t6_held", 32'(lane_held), 32'h02);
    #1 key_reset = 0;
    #1;
    chk("t6_rst_count", 32'(evt_count), 0);
    chk("t6_rst_held", 32'(lane_held), 0);
    chk("t6_rst_valid", 32'(evt_valid), 0);
    chk("t6_rst_ovf", 32'(overflow), 0);
    step(); step();
    key_reset = 1;
    step(); step(); step();
    chk("t6_noevt", 32'(evt_count), 0);
    chk("t6_noheld", 32'(lane_held), 0);
    key_state = 0; key_ascii = 0; game_time = 700; step();
    chk("t6_rel_count", 32'(evt_count), 1);
    head("t6", 2, 0, 700);
    step();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
